// File: rtl/ball_motion_control_if.sv
// ---------------------------------------------------------------------------
// ball_motion_control_if
// Groups the signals between the ball motion controller and its neighbours:
// the collision/direction logic (enable, x_du, y_du, speed, x, y, size,
// logic_go) and the VGA pixel writer (vga_x, vga_y, colour, plot), plus busy.
//   master : the ball motion controller (drives position, go and plot bus)
//   slave  : the surrounding game logic / plotter side
// ---------------------------------------------------------------------------
interface ball_motion_control_if;
  logic       enable;
  logic       x_du;
  logic       y_du;
  logic [1:0] speed;
  logic [9:0] x;
  logic [9:0] y;
  logic [9:0] size;
  logic       logic_go;
  logic [9:0] vga_x;
  logic [9:0] vga_y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;

  modport master (
    input  enable, x_du, y_du, speed,
    output x, y, size, logic_go, vga_x, vga_y, colour, plot, busy
  );

  modport slave (
    output enable, x_du, y_du, speed,
    input  x, y, size, logic_go, vga_x, vga_y, colour, plot, busy
  );
endinterface

// File: rtl/ball_motion_control.sv
// ---------------------------------------------------------------------------
// ball_motion_control
// Owns the ball position and steps it one pixel per frame tick. Each frame:
// pulse logic_go, wait SETTLE cycles for the collision logic, erase the old
// ball, move using x_du/y_du (saturating at the screen edges), redraw.
//
// Ports:
//   clk    : system clock
//   resetn : synchronous, active-low reset
//   bus    : ball_motion_control_if.master
//            in  enable, x_du, y_du, speed
//            out x, y, size, logic_go, vga_x, vga_y, colour, plot, busy
//
// Build option: define BALL_SPEED_SEL_EN to start a frame only on every
// (4 - speed)-th tick; otherwise speed is ignored and every tick starts one.
// ---------------------------------------------------------------------------
module ball_motion_control #(
  parameter int          TICK_DIV    = 833333,
  parameter int          SETTLE      = 20,
  parameter int          BALL_SIZE   = 4,
  parameter int          X_MAX       = 160,
  parameter int          Y_MAX       = 120,
  parameter int          X_START     = 80,
  parameter int          Y_START     = 100,
  parameter logic [2:0]  BALL_COLOUR = 3'b111,
  parameter logic [2:0]  BG_COLOUR   = 3'b000
) (
  input logic                   clk,
  input logic                   resetn,
  ball_motion_control_if.master bus
);

  localparam int         TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int         SW       = $clog2(SETTLE + 1);
  localparam logic [9:0] X_LIM    = 10'(X_MAX - BALL_SIZE);
  localparam logic [9:0] Y_LIM    = 10'(Y_MAX - BALL_SIZE);
  localparam logic [3:0] PIX_LAST = 4'(BALL_SIZE - 1);

  typedef enum logic [2:0] {S_IDLE, S_GO, S_SETTLE, S_ERASE, S_MOVE, S_DRAW} state_t;

  // One-pixel step that sticks at 0 and at the upper limit.
  function automatic logic [9:0] step_sat(input logic [9:0] pos, input logic up,
                                          input logic [9:0] lim);
    if (up) return (pos >= lim) ? lim : pos + 10'd1;
    else    return (pos == 10'd0) ? 10'd0 : pos - 10'd1;
  endfunction

  state_t          r_state;
  logic [TW-1:0]   r_tick_cnt;
  logic            r_pending;
  logic [SW-1:0]   r_settle;
  logic [3:0]      r_px, r_py;
  logic [9:0]      r_x, r_y;
  logic            r_logic_go;
  logic            r_plot;
  logic [9:0]      r_vga_x, r_vga_y;
  logic [2:0]      r_colour;

  logic            w_tick, w_frame_tick, w_start, w_last_pix;
  logic [3:0]      w_nx_px, w_nx_py;
  logic [9:0]      w_new_x, w_new_y;

  assign w_tick = bus.enable && (r_tick_cnt == TW'(TICK_DIV - 1));

`ifdef BALL_SPEED_SEL_EN
  // Counts ticks whose frames are suppressed; the (4 - speed)-th tick fires.
  logic [1:0] r_skip;
  logic       w_skip_hit;
  assign w_skip_hit   = (r_skip == (2'd3 - bus.speed));
  assign w_frame_tick = w_tick && w_skip_hit;
`else
  logic w_unused_speed;
  assign w_unused_speed = ^bus.speed;
  assign w_frame_tick   = w_tick;
`endif

  // A tick arriving while idle starts the frame directly instead of waiting
  // a cycle in pending.
  assign w_start    = bus.enable && (r_pending || w_frame_tick);
  assign w_last_pix = (r_px == PIX_LAST) && (r_py == PIX_LAST);
  assign w_nx_px    = (r_px == PIX_LAST) ? 4'd0 : r_px + 4'd1;
  assign w_nx_py    = (r_px == PIX_LAST) ? r_py + 4'd1 : r_py;
  assign w_new_x    = step_sat(r_x, bus.x_du, X_LIM);
  assign w_new_y    = step_sat(r_y, bus.y_du, Y_LIM);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_pending  <= 1'b0;
      r_settle   <= '0;
      r_px       <= 4'd0;
      r_py       <= 4'd0;
      r_x        <= 10'(X_START);
      r_y        <= 10'(Y_START);
      r_logic_go <= 1'b0;
      r_plot     <= 1'b0;
      r_vga_x    <= 10'd0;
      r_vga_y    <= 10'd0;
      r_colour   <= BG_COLOUR;
`ifdef BALL_SPEED_SEL_EN
      r_skip     <= 2'd0;
`endif
    end else begin
      if (bus.enable)
        r_tick_cnt <= (r_tick_cnt == TW'(TICK_DIV - 1)) ? '0 : r_tick_cnt + TW'(1);
`ifdef BALL_SPEED_SEL_EN
      if (w_tick)
        r_skip <= w_skip_hit ? 2'd0 : r_skip + 2'd1;
`endif
      // Pending is one deep: extra ticks while set are simply absorbed.
      if (r_state == S_IDLE && w_start) r_pending <= 1'b0;
      else if (w_frame_tick)            r_pending <= 1'b1;

      r_logic_go <= 1'b0;
      r_plot     <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state    <= S_GO;
            r_logic_go <= 1'b1;
          end
        end
        S_GO: begin
          r_state  <= S_SETTLE;
          r_settle <= '0;
        end
        S_SETTLE: begin
          if (r_settle == SW'(SETTLE - 1)) begin
            r_state  <= S_ERASE;
            r_px     <= 4'd0;
            r_py     <= 4'd0;
            r_plot   <= 1'b1;
            r_colour <= BG_COLOUR;
            r_vga_x  <= r_x;
            r_vga_y  <= r_y;
          end else begin
            r_settle <= r_settle + SW'(1);
          end
        end
        // Outputs are registered, so each cycle presents the pixel chosen on
        // the previous edge and the counters point at the pixel on display.
        S_ERASE, S_DRAW: begin
          if (w_last_pix) begin
            r_state <= (r_state == S_ERASE) ? S_MOVE : S_IDLE;
          end else begin
            r_px    <= w_nx_px;
            r_py    <= w_nx_py;
            r_plot  <= 1'b1;
            r_vga_x <= r_x + {6'd0, w_nx_px};
            r_vga_y <= r_y + {6'd0, w_nx_py};
          end
        end
        S_MOVE: begin
          r_x      <= w_new_x;
          r_y      <= w_new_y;
          r_state  <= S_DRAW;
          r_px     <= 4'd0;
          r_py     <= 4'd0;
          r_plot   <= 1'b1;
          r_colour <= BALL_COLOUR;
          r_vga_x  <= w_new_x;
          r_vga_y  <= w_new_y;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.x        = r_x;
  assign bus.y        = r_y;
  assign bus.size     = 10'(BALL_SIZE);
  assign bus.logic_go = r_logic_go;
  assign bus.vga_x    = r_vga_x;
  assign bus.vga_y    = r_vga_y;
  assign bus.colour   = r_colour;
  assign bus.plot     = r_plot;
  assign bus.busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_ball_motion_control.sv
// ---------------------------------------------------------------------------
// tb_ball_motion_control
// Self-checking bench for ball_motion_control: a frame-level reference model
// (tick counter, pending flag, frame phase index, saturating position) is
// compared against the DUT every cycle, plus hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_ball_motion_control;
  localparam int         TD   = 100;
  localparam int         ST   = 20;
  localparam int         B    = 4;
  localparam int         XM   = 160;
  localparam int         YM   = 120;
  localparam int         XS   = 80;
  localparam int         YS   = 100;
  localparam logic [2:0] BALL = 3'b111;
  localparam logic [2:0] BG   = 3'b000;

  // Frame phases: 0 go, 1..ST settle, ERASE0.. erase, MOVE_PH, DRAW0.. draw.
  localparam int FLEN    = 1 + ST + 2 * B * B + 1;
  localparam int ERASE0  = 1 + ST;
  localparam int MOVE_PH = ERASE0 + B * B;
  localparam int DRAW0   = MOVE_PH + 1;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  ball_motion_control_if bus_if ();

  ball_motion_control #(
    .TICK_DIV(TD), .SETTLE(ST), .BALL_SIZE(B), .X_MAX(XM), .Y_MAX(YM),
    .X_START(XS), .Y_START(YS), .BALL_COLOUR(BALL), .BG_COLOUR(BG)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus_if)
  );

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_cnt, m_pend, m_phase, m_x, m_y, m_skip;
  bit m_ft;

  function automatic int sat_step(input int p, input bit up, input int lim);
    if (up) return (p < lim) ? p + 1 : p;
    return (p > 0) ? p - 1 : p;
  endfunction

  always @(posedge clk) begin
    if (!resetn) begin
      m_cnt = 0; m_pend = 0; m_phase = -1; m_x = XS; m_y = YS; m_skip = 0;
    end else begin
      m_ft = 1'b0;
      if (bus_if.enable) begin
        if (m_cnt == TD - 1) begin
          m_cnt = 0;
`ifdef BALL_SPEED_SEL_EN
          m_skip = m_skip + 1;
          if (m_skip >= 4 - int'(bus_if.speed)) begin m_skip = 0; m_ft = 1'b1; end
`else
          m_ft = 1'b1;
`endif
        end else m_cnt = m_cnt + 1;
      end
      if (m_phase < 0) begin
        if (bus_if.enable && (m_pend != 0 || m_ft)) begin m_phase = 0; m_pend = 0; end
        else if (m_ft) m_pend = 1;
      end else begin
        if (m_ft) m_pend = 1;
        if (m_phase == MOVE_PH) begin
          m_x = sat_step(m_x, bus_if.x_du, XM - B);
          m_y = sat_step(m_y, bus_if.y_du, YM - B);
        end
        m_phase = m_phase + 1;
        if (m_phase == FLEN) m_phase = -1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_on) begin
      bit er, dr;
      int i;
      er = (m_phase >= ERASE0) && (m_phase < MOVE_PH);
      dr = (m_phase >= DRAW0) && (m_phase < FLEN);
      chk("x", int'(bus_if.x), m_x);
      chk("y", int'(bus_if.y), m_y);
      chk("size", int'(bus_if.size), B);
      chk("busy", int'(bus_if.busy), int'(m_phase >= 0));
      chk("logic_go", int'(bus_if.logic_go), int'(m_phase == 0));
      chk("plot", int'(bus_if.plot), int'(er || dr));
      if (er || dr) begin
        i = m_phase - (er ? ERASE0 : DRAW0);
        chk("vga_x", int'(bus_if.vga_x), m_x + i % B);
        chk("vga_y", int'(bus_if.vga_y), m_y + i / B);
        chk("colour", int'(bus_if.colour), int'(er ? BG : BALL));
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_go(input string name, output int n);
    n = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      n++;
      if (bus_if.logic_go) return;
    end
    chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!bus_if.busy) return;
    end
    chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic do_reset(input logic en);
    resetn = 1'b0;
    bus_if.enable = en;
    step(2);
    resetn = 1'b1;
  endtask

  int n, gap;

  initial begin
    resetn = 1'b0;
    bus_if.enable = 1'b1;
    bus_if.x_du = 1'b1;
    bus_if.y_du = 1'b0;
    bus_if.speed = 2'd3;
    step(2);
    chk_on = 1'b1;
    // reset state
    chk("rst_x", int'(bus_if.x), 80);
    chk("rst_y", int'(bus_if.y), 100);
    chk("rst_plot", int'(bus_if.plot), 0);
    chk("rst_vga_x", int'(bus_if.vga_x), 0);
    chk("rst_vga_y", int'(bus_if.vga_y), 0);
    chk("rst_colour", int'(bus_if.colour), 0);
    chk("rst_busy", int'(bus_if.busy), 0);
    chk("rst_go", int'(bus_if.logic_go), 0);
    resetn = 1'b1;

    // first frame, literal pixel positions
    wait_go("t1_go", n);
    chk("t1_first_go_cycle", n, 100);
    step(ERASE0);
    chk("t1_erase0_x", int'(bus_if.vga_x), 80);
    chk("t1_erase0_y", int'(bus_if.vga_y), 100);
    chk("t1_erase0_plot", int'(bus_if.plot), 1);
    step(B * B - 1);
    chk("t1_erase15_x", int'(bus_if.vga_x), 83);
    chk("t1_erase15_y", int'(bus_if.vga_y), 103);
    step(2);
    chk("t1_draw0_x", int'(bus_if.vga_x), 81);
    chk("t1_draw0_y", int'(bus_if.vga_y), 99);
    chk("t1_draw0_colour", int'(bus_if.colour), 7);
    step(B * B - 1);
    chk("t1_draw15_x", int'(bus_if.vga_x), 84);
    chk("t1_draw15_y", int'(bus_if.vga_y), 102);
    wait_idle("t1_idle");
    chk("t1_x", int'(bus_if.x), 81);
    chk("t1_y", int'(bus_if.y), 99);

    // drive to the low corner, then one frame x_du=0, y_du=1
    wait_idle("t2a");
    bus_if.x_du = 1'b0; bus_if.y_du = 1'b0;
    step(105 * TD);
    wait_idle("t2b");
    chk("t2_x_floor", int'(bus_if.x), 0);
    chk("t2_y_floor", int'(bus_if.y), 0);
    bus_if.y_du = 1'b1;
    wait_go("t2_go", n);
    wait_idle("t2c");
    chk("t2_x_stays0", int'(bus_if.x), 0);
    chk("t2_y_inc", int'(bus_if.y), 1);
    bus_if.x_du = 1'b1;
    step(165 * TD);
    wait_idle("t2d");
    chk("t2_x_ceil", int'(bus_if.x), 156);
    chk("t2_y_ceil", int'(bus_if.y), 116);

    // direction toggled during settle, final 0/0 at move
    wait_go("t5_go", n);
    for (int k = 0; k < ST - 5; k++) begin
      bus_if.x_du = 1'($urandom);
      bus_if.y_du = 1'($urandom);
      step(1);
    end
    bus_if.x_du = 1'b0; bus_if.y_du = 1'b0;
    wait_idle("t5_idle");
    chk("t5_x_dec", int'(bus_if.x), 155);
    chk("t5_y_dec", int'(bus_if.y), 115);

    // enable low: nothing happens; then first go 100 cycles after raising it
    do_reset(1'b0);
    n = 0;
    for (int k = 0; k < 500; k++) begin
      step(1);
      if (bus_if.logic_go || bus_if.plot) n++;
    end
    chk("t3_quiet", n, 0);
    bus_if.enable = 1'b1;
    wait_go("t3_go", n);
    chk("t3_go_latency", n, 100);

    // reset during erase aborts at once
    step(ERASE0 + 3);
    chk("t4_in_erase", int'(bus_if.plot), 1);
    resetn = 1'b0;
    step(1);
    chk("t4_plot", int'(bus_if.plot), 0);
    chk("t4_x", int'(bus_if.x), 80);
    chk("t4_y", int'(bus_if.y), 100);
    chk("t4_busy", int'(bus_if.busy), 0);
    resetn = 1'b1;

    // frame rate vs speed
    bus_if.speed = 2'd1;
    do_reset(1'b1);
    wait_go("t6_go1", n);
    wait_go("t6_go2", gap);
`ifdef BALL_SPEED_SEL_EN
    chk("t6_first", n, 300);
    chk("t6_gap", gap, 300);
`else
    chk("t6_first", n, 100);
    chk("t6_gap", gap, 100);
`endif

    // randomized run against the model
    do_reset(1'b1);
    for (int k = 0; k < 6000; k++) begin
      if (k % 200 == 0) bus_if.enable = ($urandom_range(3) != 0);
      bus_if.x_du = 1'($urandom);
      bus_if.y_du = 1'($urandom);
`ifndef BALL_SPEED_SEL_EN
      bus_if.speed = 2'($urandom);
`endif
      step(1);
    end

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
